// File: rtl/hazard_scoreboard_fwd.sv
`default_nettype none
// ==========================================================================
// hazard_scoreboard_fwd : per-register pending-latency scoreboard (ID stall)
//   and EX-stage forward selects. Optional macro: FWD_PERF_CNT_EN.  Rev 1.0
// ==========================================================================
module hazard_scoreboard_fwd #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 4,
  localparam int CW     = $clog2(MAX_LAT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold_i,
  input  logic                      issue_valid_i,
  input  logic                      issue_we_i,
  input  logic [REG_AW-1:0]         issue_rd_i,
  input  logic [CW-1:0]             issue_lat_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
  input  logic                      ex_mem_we_i,
  input  logic [REG_AW-1:0]         ex_mem_rd_i,
  input  logic                      mem_wb_we_i,
  input  logic [REG_AW-1:0]         mem_wb_rd_i,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]               stall_cycles_o,
  output logic [31:0]               fwd_events_o,
`endif
  output logic                      stall_o,
  output logic                      issue_fire_o,
  output logic [2*NUM_SRC-1:0]      fwd_sel_o
);

  localparam int NREG = 1 << REG_AW;

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [CW-1:0] lat_eff;
  logic          set_en;

  always_comb begin
    lat_eff = issue_lat_i;
    if (issue_lat_i == '0)
      lat_eff = CW'(1);
    else if (issue_lat_i > CW'(MAX_LAT))
      lat_eff = CW'(MAX_LAT);
  end

  // A counter of 1 means the result lands on a forward path in time.
  always_comb begin
    stall_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used_i[i] && (id_rs_i[i*REG_AW +: REG_AW] != '0) &&
          (cnt_q[id_rs_i[i*REG_AW +: REG_AW]] > CW'(1)))
        stall_o = 1'b1;
    end
  end

  assign issue_fire_o = issue_valid_i & ~stall_o & ~hold_i;
  assign set_en       = issue_fire_o & issue_we_i & (issue_rd_i != '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!hold_i) begin
        if (set_en && (issue_rd_i == REG_AW'(r)))
          cnt_d[r] = lat_eff;
        else if (cnt_q[r] != '0)
          cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
    end
  end

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    logic [REG_AW-1:0] ex_rs;
    assign ex_rs = ex_rs_i[i*REG_AW +: REG_AW];
    assign fwd_sel_o[2*i +: 2] =
      (ex_mem_we_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == ex_rs)) ? 2'b10 :
      (mem_wb_we_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == ex_rs)) ? 2'b01 :
                                                                       2'b00;
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fwd_events_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      if (stall_o && !hold_i && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if ((|fwd_sel_o) && (fwd_events_q != 32'hFFFF_FFFF))
        fwd_events_q <= fwd_events_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign fwd_events_o   = fwd_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_fwd.sv
`default_nettype none
// ==========================================================================
// tb_hazard_scoreboard_fwd : randomized + directed bench against a
//   ready-time reference model of the hazard scoreboard.  Rev 1.0
// ==========================================================================
module tb_hazard_scoreboard_fwd;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 4;
  localparam int CW      = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      hold;
  logic                      issue_valid;
  logic                      issue_we;
  logic [REG_AW-1:0]         issue_rd;
  logic [CW-1:0]             issue_lat;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_used;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic                      exm_we;
  logic [REG_AW-1:0]         exm_rd;
  logic                      mwb_we;
  logic [REG_AW-1:0]         mwb_rd;
  logic                      stall;
  logic                      fire;
  logic [2*NUM_SRC-1:0]      fwd_sel;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]               stall_cycles;
  logic [31:0]               fwd_events;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_fwd #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .hold_i        (hold),
    .issue_valid_i (issue_valid),
    .issue_we_i    (issue_we),
    .issue_rd_i    (issue_rd),
    .issue_lat_i   (issue_lat),
    .id_rs_i       (id_rs),
    .id_rs_used_i  (id_used),
    .ex_rs_i       (ex_rs),
    .ex_mem_we_i   (exm_we),
    .ex_mem_rd_i   (exm_rd),
    .mem_wb_we_i   (mwb_we),
    .mem_wb_rd_i   (mwb_rd),
`ifdef FWD_PERF_CNT_EN
    .stall_cycles_o(stall_cycles),
    .fwd_events_o  (fwd_events),
`endif
    .stall_o       (stall),
    .issue_fire_o  (fire),
    .fwd_sel_o     (fwd_sel)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each register records the "active cycle" index at
  // which its result becomes forwardable; ID stalls while now < ready.
  longint ready_at [1 << REG_AW];
  longint now_cyc;
  longint m_stall_cycles;
  longint m_fwd_events;

  function automatic void model_reset();
    for (int r = 0; r < (1 << REG_AW); r++) ready_at[r] = 0;
    now_cyc        = 0;
    m_stall_cycles = 0;
    m_fwd_events   = 0;
  endfunction

  function automatic logic exp_stall();
    for (int i = 0; i < NUM_SRC; i++) begin
      int r = int'(id_rs[i*REG_AW +: REG_AW]);
      if (id_used[i] && r != 0 && now_cyc < ready_at[r]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_fwd(input int i);
    int r = int'(ex_rs[i*REG_AW +: REG_AW]);
    if (exm_we && exm_rd != 0 && int'(exm_rd) == r) return 2'b10;
    if (mwb_we && mwb_rd != 0 && int'(mwb_rd) == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int eff_lat(input int l);
    if (l == 0) return 1;
    if (l > MAX_LAT) return MAX_LAT;
    return l;
  endfunction

  // Inputs are set by the caller at a negedge; check, then advance one clock.
  task automatic step(input string tag);
    logic       es;
    logic       ef;
    logic [3:0] efw;
    #1;
    es = exp_stall();
    ef = issue_valid & ~es & ~hold;
    efw = '0;
    for (int i = 0; i < NUM_SRC; i++) efw[2*i +: 2] = exp_fwd(i);
    check_eq({tag, ".stall"}, 64'(stall), 64'(es));
    check_eq({tag, ".fire"},  64'(fire),  64'(ef));
    check_eq({tag, ".fwd"},   64'(fwd_sel), 64'(efw));
`ifdef FWD_PERF_CNT_EN
    check_eq({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stall_cycles));
    check_eq({tag, ".fwd_events"},   64'(fwd_events),   64'(m_fwd_events));
`endif
    @(posedge clk);
    if (!rst) begin
      if (es && !hold) m_stall_cycles++;
      if (efw != 0) m_fwd_events++;
      if (!hold) begin
        if (ef && issue_we && issue_rd != 0)
          ready_at[issue_rd] = now_cyc + longint'(eff_lat(int'(issue_lat)));
        now_cyc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    hold = 0; issue_valid = 0; issue_we = 0; issue_rd = 0; issue_lat = 0;
    id_rs = 0; id_used = 0; ex_rs = 0; exm_we = 0; exm_rd = 0; mwb_we = 0; mwb_rd = 0;
  endtask

  task automatic issue(input int rd, input int lat);
    idle();
    issue_valid = 1; issue_we = 1; issue_rd = REG_AW'(rd); issue_lat = CW'(lat);
  endtask

  task automatic read_id(input int rs);
    idle();
    issue_valid = 1; id_rs = {5'd0, REG_AW'(rs)}; id_used = 2'b01;
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    step("reset_idle");

    // Load-like producer: one stall cycle for the dependent instruction.
    issue(7, 2); step("t2_issue");
    read_id(7);  step("t2_stall");
    read_id(7);  step("t2_go");
    check_eq("t2_stall_seen", 64'(ready_at[7]), 64'(now_cyc - 1));

    // ALU producer: no stall, then EX/MEM forward.
    issue(3, 1); step("t3_issue");
    read_id(3);  step("t3_nostall");
    idle(); ex_rs = {5'd0, 5'd3}; exm_we = 1; exm_rd = 3; step("t3_fwd");

    // EX/MEM beats MEM/WB; x0 never forwards.
    idle(); ex_rs = {5'd0, 5'd9}; exm_we = 1; exm_rd = 9; mwb_we = 1; mwb_rd = 9;
    step("t4_prio");
    idle(); ex_rs = {5'd9, 5'd0}; mwb_we = 1; mwb_rd = 9; step("t4_mwb");
    idle(); ex_rs = {5'd0, 5'd0}; exm_we = 1; exm_rd = 0; step("t4_x0");

    // Hold freezes the scoreboard.
    issue(4, 4); step("t5_issue");
    for (int k = 0; k < 3; k++) begin read_id(4); hold = 1; step("t5_hold"); end
    for (int k = 0; k < 4; k++) begin read_id(4); step("t5_release"); end

    // x0 is never pending; zero and oversize latencies saturate.
    issue(0, 4); step("t6_x0");
    read_id(0);  step("t6_x0_read");
    issue(6, 0); step("t6_lat0");
    read_id(6);  step("t6_lat0_read");
    issue(8, 7); step("t6_lat7");
    for (int k = 0; k < 4; k++) begin read_id(8); step("t6_sat"); end

    // Async reset while a counter is pending.
    issue(5, 3); step("t1_issue");
    idle(); rst = 1; model_reset();
    read_id(5); step("t1_in_reset");
    rst = 0;
    read_id(5); step("t1_after");

    for (int n = 0; n < 600; n++) begin
      hold        = ($urandom_range(0, 4) == 0);
      issue_valid = $urandom_range(0, 3) != 0;
      issue_we    = $urandom_range(0, 3) != 0;
      issue_rd    = REG_AW'($urandom_range(0, 7));
      issue_lat   = CW'($urandom_range(0, 7));
      id_rs       = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
      id_used     = 2'($urandom_range(0, 3));
      ex_rs       = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
      exm_we      = 1'($urandom_range(0, 1));
      exm_rd      = REG_AW'($urandom_range(0, 7));
      mwb_we      = 1'($urandom_range(0, 1));
      mwb_rd      = REG_AW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1; model_reset();
        step("rnd_reset");
        rst = 0;
      end else begin
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
